button_encoder: RTL and testbench

Upstream input stage for the game controller. It conditions four raw colour push-buttons and one start button: 2-flop synchronisation, per-button debounce, and encoding into the IN[1:0]/IN_VALID pair. IN_VALID is a level that stays high while the accepted button is held, so the controller can detect release by IN_VALID falling. START_GAME is the debounced start-button level.

---
 rtl/button_encoder_pkg.sv | 35 +++
 rtl/button_encoder_debounce.sv | 43 ++++
 rtl/button_encoder.sv | 107 ++++++++++
 tb/tb_button_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_encoder_pkg.sv
// Shared types and helpers for the button encoder: encoder FSM states,
// the input count and small bit-vector utilities.
package button_encoder_pkg;

    localparam int NUM_COLOURS = 4;
    localparam int NUM_INPUTS  = NUM_COLOURS + 1;

    typedef enum logic [1:0] {
        ENC_IDLE_S = 2'd0,
        ENC_HOLD_S = 2'd1,
        ENC_WAIT_S = 2'd2
    } enc_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

    // Index of the set bit; only meaningful when exactly one bit is set.
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_encoder_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer for one
// asynchronous push-button (already converted to pressed = 1).
module button_encoder_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_d
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
            // Any cycle agreeing with the debounced level restarts the run.
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_d = r_deb;

endmodule

// File: rtl/button_encoder.sv
// Game-controller input stage: polarity fix, per-button sync/debounce and
// encoding of the four colour buttons into IN / IN_VALID / MULTI.
module button_encoder
    import button_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_btn,
    input  logic       i_start_btn,
    output logic [1:0] o_in,
    output logic       o_in_valid,
    output logic       o_start_game,
    output logic       o_multi
);

    logic [NUM_INPUTS-1:0] w_raw;
    logic [NUM_INPUTS-1:0] w_deb;
    logic [3:0]            w_colour;
    logic [2:0]            w_count;

    enc_state_t r_state;
    enc_state_t w_state_next;
    logic [1:0] r_in;
    logic [1:0] w_in_next;
    logic       r_in_valid;
    logic       w_in_valid_next;
    logic       r_multi;
    logic       w_multi_next;

    assign w_raw = ACTIVE_LOW ? ~{i_start_btn, i_btn} : {i_start_btn, i_btn};

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
            button_encoder_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .i_clk  (i_clk),
                .i_rst_n(i_rst_n),
                .i_d    (w_raw[gi]),
                .o_d    (w_deb[gi])
            );
        end
    endgenerate

    assign w_colour = w_deb[3:0];
    assign w_count  = popcount4(w_colour);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ENC_IDLE_S;
            r_in       <= 2'd0;
            r_in_valid <= 1'b0;
            r_multi    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in       <= w_in_next;
            r_in_valid <= w_in_valid_next;
            r_multi    <= w_multi_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_in_next       = r_in;
        w_in_valid_next = r_in_valid;
        w_multi_next    = 1'b0;
        case (r_state)
            ENC_IDLE_S: begin
                w_in_valid_next = 1'b0;
                if (w_count == 3'd1) begin
                    w_in_next       = onehot_index(w_colour);
                    w_in_valid_next = 1'b1;
                    w_state_next    = ENC_HOLD_S;
                end else if (w_count >= 3'd2) begin
                    w_multi_next = 1'b1;
                    w_state_next = ENC_WAIT_S;
                end
            end
            ENC_HOLD_S: begin
                // Only the accepted button matters; extra presses are ignored.
                if (!w_colour[r_in]) begin
                    w_in_valid_next = 1'b0;
                    w_state_next    = (w_count == 3'd0) ? ENC_IDLE_S : ENC_WAIT_S;
                end
            end
            ENC_WAIT_S: begin
                w_in_valid_next = 1'b0;
                if (w_count == 3'd0) begin
                    w_state_next = ENC_IDLE_S;
                end
            end
            default: begin
                w_in_valid_next = 1'b0;
                w_state_next    = ENC_IDLE_S;
            end
        endcase
    end

    assign o_in         = r_in;
    assign o_in_valid   = r_in_valid;
    assign o_multi      = r_multi;
    assign o_start_game = w_deb[4];

endmodule

// File: tb/tb_button_encoder.sv
// Self-checking bench for button_encoder: directed scenarios plus random
// button activity compared every cycle against a behavioural model.
module tb_button_encoder;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'hF;
    logic       start_btn = 1'b1;
    logic [1:0] o_in;
    logic       o_in_valid;
    logic       o_start_game;
    logic       o_multi;

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_en    = 1'b0;

    always #5 clk = ~clk;

    button_encoder #(
        .DEBOUNCE_CYCLES(N),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn       (btn),
        .i_start_btn (start_btn),
        .o_in        (o_in),
        .o_in_valid  (o_in_valid),
        .o_start_game(o_start_game),
        .o_multi     (o_multi)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // A level flips once the synchronised input (raw delayed two cycles)
    // has disagreed with it for the last N cycles in a row.
    logic [4:0] hist[$];
    logic [4:0] m_deb;
    logic       m_valid, m_multi, m_wait;
    logic [1:0] m_in;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] d;
        int         n;
        bit         all_diff;
        if (!rst_n) begin
            hist = {};
            for (int i = 0; i < N + 2; i++) hist.push_back(5'd0);
            m_deb = '0; m_valid = 0; m_multi = 0; m_wait = 0; m_in = 0;
        end else begin
            d = m_deb[3:0];
            n = $countones(d);
            m_multi = 0;
            if (m_valid) begin
                if (!d[m_in]) begin
                    m_valid = 0;
                    m_wait  = (n != 0);
                end
            end else if (m_wait) begin
                if (n == 0) m_wait = 0;
            end else if (n == 1) begin
                m_valid = 1;
                for (int k = 0; k < 4; k++) if (d[k]) m_in = 2'(k);
            end else if (n >= 2) begin
                m_multi = 1;
                m_wait  = 1;
            end
            for (int k = 0; k < 5; k++) begin
                all_diff = 1;
                for (int j = 1; j <= N; j++) if (hist[j][k] == m_deb[k]) all_diff = 0;
                if (all_diff) m_deb[k] = ~m_deb[k];
            end
            void'(hist.pop_front());
            hist.push_back(~{start_btn, btn});
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            check_val("sb_valid", o_in_valid, m_valid);
            check_val("sb_in", o_in, m_in);
            check_val("sb_multi", o_multi, m_multi);
            check_val("sb_start", o_start_game, m_deb[4]);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [4:0] pressed;

    task automatic press(input logic [4:0] v);
        pressed   = v;
        btn       = ~v[3:0];
        start_btn = ~v[4];
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        press(5'd0);
        cyc(3);
        rst_n = 1'b1;
    endtask

    initial begin
        press(5'd0);
        do_reset();
        sb_en = 1'b1;
        cyc(1);
        check_val("rst_valid", o_in_valid, 0);
        check_val("rst_in", o_in, 0);
        check_val("rst_multi", o_multi, 0);
        check_val("rst_start", o_start_game, 0);

        // Clean press of colour 2 then release.
        press(5'b00100);
        cyc(6);  check_val("p2_early", o_in_valid, 0);
        cyc(1);  check_val("p2_valid", o_in_valid, 1);
                 check_val("p2_in", o_in, 2);
        cyc(13); press(5'd0);
        cyc(6);  check_val("r2_early", o_in_valid, 1);
        cyc(1);  check_val("r2_valid", o_in_valid, 0);
        $display("txn: clean press/release colour 2");

        // Three-cycle glitch on colour 1, then a held press.
        cyc(10);
        press(5'b00010); cyc(3); press(5'd0);
        cyc(12); check_val("glitch_valid", o_in_valid, 0);
        press(5'b00010);
        cyc(7);  check_val("p1_valid", o_in_valid, 1);
                 check_val("p1_in", o_in, 1);
        press(5'd0); cyc(12);
        $display("txn: glitch rejected, held press accepted on colour 1");

        // Simultaneous press of colours 0 and 3.
        press(5'b01001);
        cyc(6);  check_val("multi_early", o_multi, 0);
        cyc(1);  check_val("multi_pulse", o_multi, 1);
                 check_val("multi_valid", o_in_valid, 0);
        cyc(1);  check_val("multi_end", o_multi, 0);
        press(5'd0); cyc(12);
        press(5'b01000);
        cyc(7);  check_val("p3_valid", o_in_valid, 1);
                 check_val("p3_in", o_in, 3);
        press(5'd0); cyc(12);
        $display("txn: multi-press rejected, colour 3 accepted");

        // Second button while holding the first.
        press(5'b00010); cyc(8);
        press(5'b00110); cyc(10);
        check_val("hold_in", o_in, 1);
        check_val("hold_valid", o_in_valid, 1);
        press(5'b00100);
        cyc(7);  check_val("hold_rel", o_in_valid, 0);
        cyc(10); check_val("hold_wait", o_in_valid, 0);
        press(5'd0); cyc(10);
        press(5'b00100);
        cyc(7);  check_val("hold_re_valid", o_in_valid, 1);
                 check_val("hold_re_in", o_in, 2);
        press(5'd0); cyc(12);
        $display("txn: extra press ignored while holding colour 1");

        // Start button held for 10 cycles.
        press(5'b10000);
        cyc(5);  check_val("st_early", o_start_game, 0);
        cyc(1);  check_val("st_rise", o_start_game, 1);
                 check_val("st_valid", o_in_valid, 0);
        cyc(4);  press(5'd0);
        cyc(5);  check_val("st_hold", o_start_game, 1);
        cyc(1);  check_val("st_fall", o_start_game, 0);
        cyc(5);
        $display("txn: start button level");

        // Reset while colour 0 is held and accepted.
        press(5'b00001);
        cyc(10); check_val("rp_valid", o_in_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_val("rp_async_valid", o_in_valid, 0);
        check_val("rp_async_in", o_in, 0);
        @(negedge clk); rst_n = 1'b1;
        cyc(6);  check_val("rp_early", o_in_valid, 0);
        cyc(1);  check_val("rp_valid2", o_in_valid, 1);
                 check_val("rp_in", o_in, 0);
        press(5'd0); cyc(12);
        $display("txn: reset during held press");

        // Random activity against the model.
        for (int t = 0; t < 4000; t++) begin
            int r;
            logic [4:0] v;
            @(negedge clk);
            r = $urandom_range(0, 99);
            v = pressed;
            if (r < 8) begin
                v[$urandom_range(0, 4)] ^= 1'b1;
                press(v);
            end else if (r == 8) begin
                v[3:0] = 4'($urandom_range(0, 15));
                press(v);
            end else if (r == 9 && $urandom_range(0, 15) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end
        end
        $display("txn: random phase done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
